// File: rtl/operand_fetch.sv
// Operand-fetch stage: reads the register file, bypasses writeback data, tracks
// in-flight destinations in a scoreboard and holds one instruction for execute.
module operand_fetch #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rs1,
  input  logic [ADDR_WIDTH-1:0] in_rs2,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_rd_en,
  output logic [ADDR_WIDTH-1:0] raddr1,
  output logic [ADDR_WIDTH-1:0] raddr2,
  input  logic [DATA_WIDTH-1:0] rdata1,
  input  logic [DATA_WIDTH-1:0] rdata2,
  input  logic                  wb_wen,
  input  logic [ADDR_WIDTH-1:0] wb_waddr,
  input  logic [DATA_WIDTH-1:0] wb_wdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_op1,
  output logic [DATA_WIDTH-1:0] out_op2,
  output logic [ADDR_WIDTH-1:0] out_rd,
  output logic                  out_rd_en,
  output logic [31:0]           stall_cnt
);

  localparam int NREG = 1 << ADDR_WIDTH;

  logic [NREG-1:0]       busy_r;
  logic [NREG-1:0]       busy_nxt_s;
  logic                  clr_s;
  logic                  set_s;
  logic                  hazard_s;
  logic                  accept_s;
  logic [DATA_WIDTH-1:0] op1_s;
  logic [DATA_WIDTH-1:0] op2_s;

  // A register pending writeback stops being busy in the cycle its result appears.
  function automatic logic busy_eff(input logic [NREG-1:0] busy,
                                    input logic clr,
                                    input logic [ADDR_WIDTH-1:0] waddr,
                                    input logic [ADDR_WIDTH-1:0] idx);
    return busy[idx] && !(clr && (waddr == idx));
  endfunction

  assign raddr1   = in_rs1;
  assign raddr2   = in_rs2;
  assign clr_s    = wb_wen && (wb_waddr != {ADDR_WIDTH{1'b0}});
  assign hazard_s = busy_eff(busy_r, clr_s, wb_waddr, in_rs1) ||
                    busy_eff(busy_r, clr_s, wb_waddr, in_rs2) ||
                    (in_rd_en && busy_eff(busy_r, clr_s, wb_waddr, in_rd));
  assign in_ready = (!out_valid || out_ready) && !hazard_s;
  assign accept_s = in_valid && in_ready;
  assign set_s    = accept_s && in_rd_en && (in_rd != {ADDR_WIDTH{1'b0}});

  // Operand selection: writeback bypass, then x0, then register-file data.
  always_comb begin
    op1_s = rdata1;
    op2_s = rdata2;
    if (clr_s && (wb_waddr == in_rs1)) begin
      op1_s = wb_wdata;
    end else if (in_rs1 == {ADDR_WIDTH{1'b0}}) begin
      op1_s = {DATA_WIDTH{1'b0}};
    end else begin
      op1_s = rdata1;
    end
    if (clr_s && (wb_waddr == in_rs2)) begin
      op2_s = wb_wdata;
    end else if (in_rs2 == {ADDR_WIDTH{1'b0}}) begin
      op2_s = {DATA_WIDTH{1'b0}};
    end else begin
      op2_s = rdata2;
    end
  end

  // Scoreboard next state: clear applied first so a same-index set wins.
  always_comb begin
    busy_nxt_s = busy_r;
    if (clr_s) begin
      busy_nxt_s[wb_waddr] = 1'b0;
    end else begin
      busy_nxt_s = busy_r;
    end
    if (set_s) begin
      busy_nxt_s[in_rd] = 1'b1;
    end else begin
      busy_nxt_s[0] = 1'b0;
    end
    busy_nxt_s[0] = 1'b0;
  end

  // Output register, scoreboard and stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_op1   <= {DATA_WIDTH{1'b0}};
      out_op2   <= {DATA_WIDTH{1'b0}};
      out_rd    <= {ADDR_WIDTH{1'b0}};
      out_rd_en <= 1'b0;
      busy_r    <= {NREG{1'b0}};
      stall_cnt <= 32'd0;
    end else begin
      busy_r <= busy_nxt_s;
      if (accept_s) begin
        out_valid <= 1'b1;
        out_op1   <= op1_s;
        out_op2   <= op2_s;
        out_rd    <= in_rd;
        out_rd_en <= in_rd_en;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (in_valid && hazard_s) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a small register-file array feeding the read ports.
module tb_operand_fetch;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [4:0]  in_rd;
  logic        in_rd_en;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        wb_wen;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_op1;
  logic [31:0] out_op2;
  logic [4:0]  out_rd;
  logic        out_rd_en;
  logic [31:0] stall_cnt;

  logic [31:0] rf [32];
  int checks;
  int errors;

  operand_fetch #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_en(in_rd_en),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd), .out_rd_en(out_rd_en),
    .stall_cnt(stall_cnt)
  );

  assign rdata1 = rf[raddr1];
  assign rdata2 = rf[raddr2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic rd_en);
    in_valid = 1'b1;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_rd    = rd;
    in_rd_en = rd_en;
  endtask

  task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
    wb_wen   = en;
    wb_waddr = a;
    wb_wdata = d;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rf[3] = 32'h0000_0011;
    rf[4] = 32'h0000_0022;
    rf[5] = 32'h0000_0555;
    rf[7] = 32'h0000_0777;
    rf[9] = 32'h0000_0909;
    rst = 1'b1;
    out_ready = 1'b1;
    wb(1'b0, 5'd0, 32'h0);
    offer(5'd3, 5'd4, 5'd0, 1'b0);

    // Reset with in_valid high: nothing captured
    tick();
    tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_stall", stall_cnt, 32'd0);
    chk("rst_op1", out_op1, 32'd0);

    // Simple fetch
    rst = 1'b0;
    #1;
    chk("fetch_ready", 32'(in_ready), 32'd1);
    tick();
    chk("fetch_valid", 32'(out_valid), 32'd1);
    chk("fetch_op1", out_op1, 32'h11);
    chk("fetch_op2", out_op2, 32'h22);

    // RAW stall plus bypass
    offer(5'd0, 5'd0, 5'd5, 1'b1);
    #1;
    chk("raw_prod_ready", 32'(in_ready), 32'd1);
    tick();
    chk("raw_prod_rd", 32'(out_rd), 32'd5);
    offer(5'd5, 5'd0, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("raw_stall_ready", 32'(in_ready), 32'd0);
      tick();
    end
    wb(1'b1, 5'd5, 32'h0000_DEAD);
    #1;
    chk("raw_wb_ready", 32'(in_ready), 32'd1);
    tick();
    chk("raw_bypass_op1", out_op1, 32'h0000_DEAD);
    chk("raw_valid", 32'(out_valid), 32'd1);
    chk("raw_stall_cnt", stall_cnt, 32'd3);
    wb(1'b0, 5'd0, 32'h0);

    // x0 handling
    offer(5'd0, 5'd0, 5'd0, 1'b1);
    #1;
    chk("x0_rd_ready", 32'(in_ready), 32'd1);
    tick();
    chk("x0_rd_en", 32'(out_rd_en), 32'd1);
    wb(1'b1, 5'd0, 32'hFFFF_FFFF);
    #1;
    chk("x0_use_ready", 32'(in_ready), 32'd1);
    tick();
    chk("x0_op1", out_op1, 32'h0);
    chk("x0_op2", out_op2, 32'h0);
    chk("x0_stall_cnt", stall_cnt, 32'd3);
    wb(1'b0, 5'd0, 32'h0);

    // Same-cycle set/clear on x7
    offer(5'd0, 5'd0, 5'd7, 1'b1);
    tick();
    wb(1'b1, 5'd7, 32'h0000_0077);
    #1;
    chk("sc_ready", 32'(in_ready), 32'd1);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    offer(5'd7, 5'd0, 5'd0, 1'b0);
    #1;
    chk("sc_busy_stall", 32'(in_ready), 32'd0);
    tick();
    chk("sc_stall_cnt", stall_cnt, 32'd4);
    wb(1'b1, 5'd7, 32'h0000_0099);
    #1;
    chk("sc_release", 32'(in_ready), 32'd1);
    tick();
    chk("sc_op1", out_op1, 32'h0000_0099);
    wb(1'b0, 5'd0, 32'h0);

    // Back-pressure holds outputs and is not counted as a stall
    out_ready = 1'b0;
    offer(5'd3, 5'd4, 5'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_ready", 32'(in_ready), 32'd0);
      tick();
      chk("bp_op1", out_op1, 32'h0000_0099);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_stall_cnt", stall_cnt, 32'd4);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    tick();
    chk("bp_new_op1", out_op1, 32'h11);
    chk("bp_new_op2", out_op2, 32'h22);
    chk("bp_new_valid", 32'(out_valid), 32'd1);

    // Reset mid-stall clears scoreboard and held instruction
    offer(5'd0, 5'd0, 5'd9, 1'b1);
    tick();
    offer(5'd9, 5'd0, 5'd0, 1'b0);
    #1;
    chk("ms_stall", 32'(in_ready), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("ms_rst_valid", 32'(out_valid), 32'd0);
    chk("ms_rst_stall", stall_cnt, 32'd0);
    chk("ms_rst_rd", 32'(out_rd), 32'd0);
    rst = 1'b0;
    #1;
    chk("ms_ready", 32'(in_ready), 32'd1);
    tick();
    chk("ms_op1", out_op1, 32'h0000_0909);

    // Drain: consumed with no new offer
    in_valid = 1'b0;
    tick();
    chk("drain_valid", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand-fetch stage between instruction decode and execute. Drives the register file's two combinational read ports and captures source operands into a one-entry output register behind a valid/ready handshake. Tracks in-flight destination registers in a scoreboard and stalls on RAW/WAW hazards. Bypasses the register-file write port so that a same-cycle writeback is never missed.

## Interface
- DATA_WIDTH, 32, operand/data width
- ADDR_WIDTH, 5, register index width (32 registers, x0 hardwired zero)

- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decode offers an instruction
- in_ready  out  1  stage accepts this cycle
- in_rs1, in_rs2  in  ADDR_WIDTH  source register indices
- in_rd  in  ADDR_WIDTH  destination index
- in_rd_en  in  1  instruction writes in_rd
- raddr1, raddr2  out  ADDR_WIDTH  register-file read addresses
- rdata1, rdata2  in  DATA_WIDTH  register-file read data (combinational)
- wb_wen, wb_waddr, wb_wdata  in  1/ADDR_WIDTH/DATA_WIDTH  copy of the register-file write port
- out_valid  out  1  operands held for execute
- out_ready  in  1  execute consumes
- out_op1, out_op2  out  DATA_WIDTH  captured operands
- out_rd  out  ADDR_WIDTH, out_rd_en  out  1  forwarded destination
- stall_cnt  out  32  hazard-stall cycle counter

## Operation
- raddr1 = in_rs1, raddr2 = in_rs2, purely combinational.
- Scoreboard: busy[31:0] register; busy[0] is constant 0.
- clr = wb_wen && wb_waddr != 0; it clears busy[wb_waddr].
- set = in_valid && in_ready && in_rd_en && in_rd != 0; it sets busy[in_rd].
- When set and clr hit the same index in one cycle, set wins and the bit stays 1.
- busy_eff(r) = busy[r] && !(clr && wb_waddr == r).
- hazard = busy_eff(in_rs1) || busy_eff(in_rs2) || (in_rd_en && busy_eff(in_rd)).
  - Index 0 is never busy.
  - Operands are checked unconditionally; there is no per-operand use flag.
- in_ready = (!out_valid || out_ready) && !hazard. in_ready does not depend on in_valid.
- Operand select, per port n:
  - if clr && wb_waddr == in_rsn, use wb_wdata;
  - else if in_rsn == 0, use 0;
  - else use rdatan.
- Capture on in_valid && in_ready: out_op1/out_op2/out_rd/out_rd_en are loaded and out_valid becomes 1.
- Otherwise, out_valid && out_ready clears out_valid. Data registers hold their last value.
- stall_cnt increments by 1 (wrapping at 2^32) on every cycle with in_valid && hazard.
  - Back-pressure-only stalls, where out_valid && !out_ready with no hazard, are not counted.
- Writebacks are assumed in program order. Reordering is prevented by the WAW stall, not handled here.

## Timing
- Reset (rst high at posedge) sets out_valid=0, out_op1=0, out_op2=0, out_rd=0, out_rd_en=0, busy=0, stall_cnt=0.
  - Reset overrides any simultaneous capture or writeback.
  - Reset mid-stall discards the held instruction.
- Latency: an instruction accepted at edge N is visible on the outputs after edge N, i.e. in cycle N+1.
- Throughput: one instruction per cycle when there are no hazards and out_ready=1.
  - Capture and consume in the same cycle is allowed.
- The out_* signals stay stable while out_valid && !out_ready.
- A hazard resolves the same cycle the matching writeback is on wb_*: in_ready rises combinationally and the bypassed data is captured.
- Back-to-back dependency stalls: producer accepted at N, consumer stalls until its writeback cycle W and is captured at the end of W.
- No combinational path from out_ready to out_*. The out_ready → in_ready path is allowed.

## Test plan
- Reset: assert rst for 2 cycles with in_valid=1 → out_valid=0, stall_cnt=0, busy=0. The first accept happens only after rst drops.
- Simple fetch: rs1=3, rs2=4, with regfile holding x3=0x11, x4=0x22, out_ready=1 → next cycle out_op1=0x11, out_op2=0x22, out_valid=1.
- RAW stall plus bypass:
  - accept rd=5 (rd_en=1), then offer rs1=5;
  - hold wb_wen=0 for 3 cycles, then wb_wen=1, wb_waddr=5, wb_wdata=0xDEAD;
  - expect in_ready=0 for 3 cycles, then 1 in the wb cycle, out_op1=0xDEAD, stall_cnt=3.
- x0 handling: rd_en=1 with rd=0, followed by rs1=0, rs2=0 → no stall, operands 0. A wb to x0 with data 0xFFFF_FFFF is not bypassed.
- Same-cycle set/clear: busy[7] set, wb clears x7 while a new instruction with rd=7 is accepted → busy[7] stays 1. A following rs1=7 stalls.
- Back-pressure: out_ready=0 for 4 cycles with a captured instruction → out_* stable, in_ready=0, stall_cnt unchanged. out_ready=1 releases and a new capture occurs in the same cycle.
